mem_subsys_mmio: RTL

Parametrised memory subsystem for the multicycle stack processor. It holds a synchronous single-port RAM, the instruction register (IR) and a memory output register. It also provides N_IO memory-mapped I/O channels, all behind a req/ready handshake. It sits between the control unit / datapath (PC, ALUout and B registers) and the board I/O, replacing the fixed-width, single-I/O memory subsystem.

---
 rtl/mem_subsys_mmio_if.sv | 33 +++
 rtl/mem_subsys_mmio.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mem_subsys_mmio_if.sv
// Bus between the control unit / datapath and the memory subsystem.
//
// Handshake: the master raises req with IorD/wea/IRWrite/PCWire/ALUoutWire/
// bWire valid; a transfer is accepted on any rising clk edge where req=1 and
// ready=1. All request fields are captured on that edge and are don't-care
// afterwards. While ready=0, req is ignored and never queued. IRw, Memoutw
// and addr_err are driven by the slave and change only on clk edges or reset.
interface mem_subsys_mmio_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req;
    logic              IorD;
    logic              wea;
    logic              IRWrite;
    logic [ADDR_W-1:0] PCWire;
    logic [ADDR_W-1:0] ALUoutWire;
    logic [DATA_W-1:0] bWire;
    logic              ready;
    logic [DATA_W-1:0] IRw;
    logic [DATA_W-1:0] Memoutw;
    logic              addr_err;

    modport master (
        output req, IorD, wea, IRWrite, PCWire, ALUoutWire, bWire,
        input  ready, IRw, Memoutw, addr_err
    );

    modport slave (
        input  req, IorD, wea, IRWrite, PCWire, ALUoutWire, bWire,
        output ready, IRw, Memoutw, addr_err
    );
endinterface

// File: rtl/mem_subsys_mmio.sv
// Memory subsystem for the multicycle stack processor: synchronous RAM,
// instruction register, memory output register and N_IO memory-mapped
// I/O channels, sequenced by a three-state IDLE/ACCESS/RESP controller.
module mem_subsys_mmio #(
    parameter int              DATA_W    = 16,
    parameter int              ADDR_W    = 16,
    parameter int              MEM_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] IO_BASE = 16'hFF00,
    parameter int              N_IO      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_subsys_mmio_if.slave       bus,
    input  logic [N_IO*DATA_W-1:0] input_IO,
    output logic [N_IO*DATA_W-1:0] output_IO,
    output logic [N_IO-1:0]        io_strobe,
    output logic [1:0]             fsm_state
);
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int CH_W   = (N_IO > 1) ? $clog2(N_IO) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic                   we_q;
    logic                   irw_q;
    logic [DATA_W-1:0]      mem [MEM_DEPTH];
    logic [DATA_W-1:0]      ram_q;
    logic [DATA_W-1:0]      other_q;
    logic                   use_ram_q;
    logic [N_IO*DATA_W-1:0] cap_q;
    logic [DATA_W-1:0]      ir_q;
    logic [DATA_W-1:0]      mem_out_q;
    logic                   err_q;

    logic [ADDR_W-1:0] off;
    logic              is_ram;
    logic              is_io;
    logic              is_unmapped;
    logic [CH_W-1:0]   ch;
    logic [MEM_AW-1:0] idx;
    logic [DATA_W-1:0] result;

    assign bus.ready    = (state == IDLE);
    assign bus.IRw      = ir_q;
    assign bus.Memoutw  = mem_out_q;
    assign bus.addr_err = err_q;
    assign fsm_state    = state;

    // Address decode of the latched address into RAM / I/O / unmapped.
    always_comb begin
        off         = addr_q - IO_BASE;
        is_ram      = (addr_q < IO_BASE);
        is_io       = !is_ram && (off < ADDR_W'(N_IO));
        is_unmapped = !is_ram && !is_io;
        ch          = off[CH_W-1:0];
        idx         = addr_q[MEM_AW-1:0];
        result      = use_ram_q ? ram_q : other_q;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic: one access takes IDLE -> ACCESS -> RESP -> IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Capture the request fields on the accepting edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            irw_q   <= 1'b0;
        end else if (state == IDLE && bus.req) begin
            addr_q  <= bus.IorD ? bus.ALUoutWire : bus.PCWire;
            wdata_q <= bus.bWire;
            we_q    <= bus.wea;
            irw_q   <= bus.IRWrite;
        end
    end

    // RAM port: no reset so it maps onto block RAM; the address wraps mod MEM_DEPTH.
    always_ff @(posedge clk) begin
        if (state == ACCESS && is_ram) begin
            if (we_q) mem[idx] <= wdata_q;
            ram_q <= mem[idx];
        end
    end

    // Non-RAM result, I/O writes and RESP-cycle pulses, all on the edge leaving ACCESS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            other_q   <= '0;
            use_ram_q <= 1'b0;
            output_IO <= '0;
            io_strobe <= '0;
            err_q     <= 1'b0;
        end else begin
            io_strobe <= '0;
            err_q     <= 1'b0;
            if (state == ACCESS) begin
                use_ram_q <= is_ram && !we_q;
                if (we_q)       other_q <= wdata_q;
                else if (is_io) other_q <= cap_q[ch*DATA_W +: DATA_W];
                else            other_q <= '0;
                if (is_io && we_q) begin
                    output_IO[ch*DATA_W +: DATA_W] <= wdata_q;
                    io_strobe <= N_IO'(1) << ch;
                end
                err_q <= is_unmapped;
            end
        end
    end

    // One-stage capture of the input channels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cap_q <= '0;
        else        cap_q <= input_IO;
    end

    // Memoutw and IR update on the edge leaving RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_out_q <= '0;
            ir_q      <= '0;
        end else if (state == RESP) begin
            mem_out_q <= result;
            if (irw_q) ir_q <= result;
        end
    end
endmodule
